// File: rtl/toggle_debounce_if.sv
// Button-side bundle for the toggle debouncer: raw button in, toggle pulse,
// debounced level and press count out.
interface toggle_debounce_if;
    logic       btn;
    logic       t;
    logic       pressed;
    logic [7:0] press_cnt;

    modport master (output btn, input  t, pressed, press_cnt);
    modport slave  (input  btn, output t, pressed, press_cnt);
endinterface

// File: rtl/toggle_debounce.sv
// Push-button debouncer: synchronizes a bouncing button, accepts a level change
// after DB_CYCLES stable samples and emits one toggle pulse per accepted press.
module toggle_debounce #(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    toggle_debounce_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    logic             r_s1_p0;
    logic             r_s2_p1;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             r_t;
    logic             r_pressed;
    logic [7:0]       r_press_cnt;

    // Stage 0/1: two-flop synchronizer on the asynchronous button level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_p0 <= 1'b0;
            r_s2_p1 <= 1'b0;
        end else begin
            r_s1_p0 <= bus.btn;
            r_s2_p1 <= r_s1_p0;
        end
    end

    // Stage 2: debounce state and stability counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_s2_p1) begin
                    w_state_nxt = CHK_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_PRESS: begin
                if (!r_s2_p1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!r_s2_p1) begin
                    w_state_nxt = CHK_REL;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_REL: begin
                // A bounce back high keeps the press alive without a new pulse
                if (r_s2_p1) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Stage 3: registered outputs; the count advances on the same edge t is set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t         <= 1'b0;
            r_pressed   <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_t       <= w_accept;
            r_pressed <= (w_state_nxt == PRESSED) || (w_state_nxt == CHK_REL);
            if (w_accept) begin
                r_press_cnt <= r_press_cnt + 8'd1;
            end
        end
    end

    assign bus.t         = r_t;
    assign bus.pressed   = r_pressed;
    assign bus.press_cnt = r_press_cnt;
endmodule

// File: tb/tb_toggle_debounce.sv
// Directed bench for toggle_debounce: segment table plus hand-written latency,
// reset, downstream T flip-flop and counter wrap sequences.
module tb_toggle_debounce;
    logic clk = 1'b0;
    logic reset;
    logic q;
    logic q_prev;

    int n_chk  = 0;
    int n_err  = 0;
    int t_seen = 0;
    int q_tog  = 0;

    always #5 clk = ~clk;

    toggle_debounce_if bus ();

    toggle_debounce #(
        .DB_CYCLES(8),
        .CNT_W    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Downstream T flip-flop driven by the toggle pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= 1'b0;
        else if (bus.t) q <= ~q;
    end

    typedef struct {
        logic btn;
        int   cycles;
        int   exp_t;
        logic exp_pressed;
        int   exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.t) t_seen++;
        if (q !== q_prev) q_tog++;
        q_prev = q;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clean_press();
        bus.btn = 1'b1;
        ticks(12);
        bus.btn = 1'b0;
        ticks(12);
    endtask

    initial begin
        int t_before;

        reset   = 1'b0;
        bus.btn = 1'b0;
        q_prev  = 1'b0;
        ticks(3);
        check("reset_t", int'(bus.t), 0);
        check("reset_pressed", int'(bus.pressed), 0);
        check("reset_press_cnt", int'(bus.press_cnt), 0);
        reset = 1'b1;
        ticks(3);

        // Clean press: t only after edge 10, pressed from edge 10
        bus.btn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("lat_t_e%0d", k), int'(bus.t), (k == 10) ? 1 : 0);
            check($sformatf("lat_pressed_e%0d", k), int'(bus.pressed), (k >= 10) ? 1 : 0);
        end
        check("lat_press_cnt", int'(bus.press_cnt), 1);
        bus.btn = 1'b0;
        ticks(15);
        check("lat_release", int'(bus.pressed), 0);

        vecs.push_back('{1'b0,  5, 0, 1'b0, 1});
        vecs.push_back('{1'b1,  5, 0, 1'b0, 1});  // glitch
        vecs.push_back('{1'b0, 10, 0, 1'b0, 1});
        vecs.push_back('{1'b1, 20, 1, 1'b1, 2});  // clean press
        vecs.push_back('{1'b0,  3, 0, 1'b1, 2});
        vecs.push_back('{1'b1,  5, 0, 1'b1, 2});  // bounce during release check
        vecs.push_back('{1'b0, 15, 0, 1'b0, 2});
        vecs.push_back('{1'b1,  8, 0, 1'b0, 2});  // one sample short of acceptance
        vecs.push_back('{1'b0, 10, 0, 1'b0, 2});
        for (int i = 0; i < 3; i++) begin        // bouncy press
            vecs.push_back('{1'b1, 1, 0, 1'b0, 2});
            vecs.push_back('{1'b0, 1, 0, 1'b0, 2});
        end
        vecs.push_back('{1'b1, 20, 1, 1'b1, 3});
        for (int i = 0; i < 3; i++) begin        // bouncy release
            vecs.push_back('{1'b0, 1, 0, 1'b1, 3});
            vecs.push_back('{1'b1, 1, 0, 1'b1, 3});
        end
        vecs.push_back('{1'b0, 20, 0, 1'b0, 3});

        foreach (vecs[i]) begin
            t_before = t_seen;
            bus.btn  = vecs[i].btn;
            ticks(vecs[i].cycles);
            check($sformatf("vec%0d_t", i), t_seen - t_before, vecs[i].exp_t);
            check($sformatf("vec%0d_pressed", i), int'(bus.pressed), int'(vecs[i].exp_pressed));
            check($sformatf("vec%0d_press_cnt", i), int'(bus.press_cnt), vecs[i].exp_cnt);
        end

        // Reset in CHK_PRESS with cnt=5, button held through release
        t_before = t_seen;
        bus.btn  = 1'b1;
        ticks(8);
        check("midchk_no_t", t_seen - t_before, 0);
        check("midchk_pressed", int'(bus.pressed), 0);
        #1 reset = 1'b0;
        #1;
        check("midchk_rst_t", int'(bus.t), 0);
        check("midchk_rst_pressed", int'(bus.pressed), 0);
        check("midchk_rst_press_cnt", int'(bus.press_cnt), 0);
        ticks(2);
        check("midchk_hold_press_cnt", int'(bus.press_cnt), 0);
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("relat_t_e%0d", k), int'(bus.t), (k == 10) ? 1 : 0);
        end
        check("relat_press_cnt", int'(bus.press_cnt), 1);

        // Reset landing in the t=1 cycle
        bus.btn = 1'b0;
        ticks(15);
        bus.btn = 1'b1;
        ticks(11);
        check("tcyc_pre_t", int'(bus.t), 1);
        #1 reset = 1'b0;
        #1;
        check("tcyc_rst_t", int'(bus.t), 0);
        check("tcyc_rst_press_cnt", int'(bus.press_cnt), 0);
        tick();
        bus.btn = 1'b0;
        reset   = 1'b1;
        t_before = t_seen;
        ticks(15);
        check("tcyc_after_t", t_seen - t_before, 0);
        check("tcyc_after_pressed", int'(bus.pressed), 0);

        // Downstream T flip-flop: 3 presses, 3 toggles
        t_seen = 0;
        q_tog  = 0;
        q_prev = q;
        for (int i = 0; i < 3; i++) clean_press();
        check("tff_t_pulses", t_seen, 3);
        check("tff_q_toggles", q_tog, 3);
        check("tff_press_cnt", int'(bus.press_cnt), 3);

        // Counter wrap after 256 presses
        for (int i = 0; i < 252; i++) clean_press();
        check("wrap_255", int'(bus.press_cnt), 255);
        clean_press();
        check("wrap_0", int'(bus.press_cnt), 0);
        check("wrap_t_pulses", t_seen, 256);
        check("wrap_q_toggles", q_tog, 256);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/toggle_debounce.md
TOGGLE_DEBOUNCE -- requirements
Module: toggle_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 8: number of consecutive synchronized samples required to accept a level change; legal range 2..2**CNT_W.
REQ-002 SHALL have parameter CNT_W, default 4: width of the internal debounce counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
REQ-005 SHALL have port btn  input  1: raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 SHALL have port t  output  1: registered one-cycle toggle-request pulse, per accepted press; drives the T input of the downstream T flip-flop.
REQ-007 SHALL have port pressed  output  1: registered debounced button level.
REQ-008 SHALL have port press_cnt  output  8: registered count of accepted presses.

Function
REQ-009 SHALL pass btn through a two-flop synchronizer (s1, s2); only s2 feeds control logic.
REQ-010 SHALL implement FSM states IDLE, CHK_PRESS, PRESSED, CHK_REL.
REQ-011 In IDLE: s2=1 -> CHK_PRESS, cnt<=0; otherwise stay.
REQ-012 In CHK_PRESS: s2=0 -> IDLE, cnt<=0 (bounce rejected, no t); s2=1 and cnt=DB_CYCLES-1 -> PRESSED; otherwise cnt<=cnt+1.
REQ-013 In PRESSED: s2=0 -> CHK_REL, cnt<=0; otherwise stay.
REQ-014 In CHK_REL: s2=1 -> PRESSED, no t; s2=0 and cnt=DB_CYCLES-1 -> IDLE; otherwise cnt<=cnt+1.
REQ-015 t SHALL be 1 for exactly the one cycle following the CHK_PRESS->PRESSED transition; t SHALL be 0 in all other cycles.
REQ-016 pressed SHALL be 1 while state is PRESSED or CHK_REL; 0 otherwise.
REQ-017 press_cnt SHALL increment by 1 on each clock edge that registers t=1; it SHALL wrap 255 -> 0 with no flag.
REQ-018 Latency: btn rising and held stable from edge E0 SHALL produce t=1 after edge E0+DB_CYCLES+2 (edge 10 for default).
REQ-019 A btn high pulse spanning fewer than DB_CYCLES+1 consecutive sampling edges SHALL produce no t and no change of pressed.
REQ-020 Bounce during CHK_REL SHALL return to PRESSED without t; one physical press SHALL yield exactly one t pulse.
REQ-021 btn held high through reset release SHALL be treated as a new press: exactly one t after the debounce latency.
REQ-022 cnt SHALL never exceed DB_CYCLES-1; no counter overflow path exists.

Reset
REQ-023 reset=0 SHALL asynchronously force s1=0, s2=0, state=IDLE, cnt=0, t=0, pressed=0, press_cnt=0.
REQ-024 Reset asserted mid-operation (any state, incl. the t=1 cycle) SHALL clear t in the same instant and discard the in-progress debounce.
REQ-025 After reset release the block SHALL resume on the first rising clk edge with reset=1.

Verification
REQ-026 Clean press, DB_CYCLES=8: btn 0->1 before edge 0, held 40 cycles -> t=1 only in the cycle after edge 10, pressed=1 from edge 10, press_cnt=1.
REQ-027 Glitch: btn high for 5 cycles then low -> t never 1, pressed stays 0, press_cnt=0.
REQ-028 Bouncy press: btn toggles 1,0,1,0 each cycle for 6 cycles, then held high 20 cycles -> exactly one t pulse, press_cnt=1; bouncy release -> pressed falls once, no t.
REQ-029 Wrap: 256 clean presses -> 256 t pulses, press_cnt returns to 0.
REQ-030 Reset mid-CHK_PRESS (btn high, cnt=5): reset=0 for 2 cycles with btn held -> all outputs 0 immediately; after release t arrives DB_CYCLES+2 edges later.
REQ-031 Downstream check: t feeding the T flip-flop, 3 clean presses -> its q toggles exactly 3 times.
